// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame scheduler.
package adc_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_SYNC,
      SEND_CH1,
      SEND_CH2,
      SEND_CHK
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         FRAME_LEN     = 4;

   // Frame checksum covers the sync byte as well as both samples.
   function automatic logic [7:0] frame_chk(input logic [7:0] ch1, input logic [7:0] ch2,
                                            input logic [7:0] sync);
      return ch1 ^ ch2 ^ sync;
   endfunction

endpackage

// File: rtl/adc_frame_scheduler_if.sv
// Byte-wide valid/ready link from the scheduler to the serial transmitter.
interface adc_frame_scheduler_if #(
   parameter int DATA_SIZE = 8
) ();
   logic [DATA_SIZE-1:0] o_tx_data;
   logic                 o_tx_valid;
   logic                 i_tx_ready;

   modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
   modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/sample_tick_gen.sv
// Decimation counter producing a one-cycle sample tick, qualified by ADC readiness.
module sample_tick_gen #(
   parameter int DECIM_SIZE = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_adc_ready,
   input  logic [DECIM_SIZE-1:0] i_decim,
   output logic                  o_tick
);
   logic [DECIM_SIZE-1:0] cnt;
   logic                  wrap;

   // >= lets a lowered decimation value take effect on the next cycle.
   assign wrap   = (cnt >= i_decim);
   assign o_tick = i_enable & i_adc_ready & wrap;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)      cnt <= '0;
      else if (!i_enable) cnt <= '0;
      else if (wrap)     cnt <= '0;
      else               cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/adc_frame_scheduler.sv
// Snapshots both ADC channels on each sample tick and streams a sync/ch1/ch2/chk frame.
module adc_frame_scheduler
   import adc_frame_pkg::*;
#(
   parameter int                   DATA_SIZE  = 8,
   parameter int                   DECIM_SIZE = 16,
   parameter logic [DATA_SIZE-1:0] SYNC_BYTE  = DATA_SIZE'(SYNC_BYTE_DEF)
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_adc_ready,
   input  logic [DECIM_SIZE-1:0]   i_decim,
   input  logic [DATA_SIZE-1:0]    i_ch1_data,
   input  logic [DATA_SIZE-1:0]    i_ch2_data,
   adc_frame_scheduler_if.master   tx,
   input  logic                    i_clear_overrun,
   output logic [7:0]              o_overrun_count,
   output logic                    o_busy
);
   state_t               state, state_nxt;
   logic [DATA_SIZE-1:0] hold_ch1, hold_ch2, chk;
   logic [DATA_SIZE-1:0] data_nxt;
   logic                 tick, handshake, capture;

   sample_tick_gen #(.DECIM_SIZE(DECIM_SIZE)) u_tick (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_enable    (i_enable),
      .i_adc_ready (i_adc_ready),
      .i_decim     (i_decim),
      .o_tick      (tick)
   );

   always_comb begin
      handshake = tx.o_tx_valid & tx.i_tx_ready;
      // The last byte leaving frees the hold registers in the same cycle.
      capture   = tick & ((state == IDLE) | ((state == SEND_CHK) & handshake));
      state_nxt = state;
      case (state)
         IDLE:      if (capture)   state_nxt = SEND_SYNC;
         SEND_SYNC: if (handshake) state_nxt = SEND_CH1;
         SEND_CH1:  if (handshake) state_nxt = SEND_CH2;
         SEND_CH2:  if (handshake) state_nxt = SEND_CHK;
         SEND_CHK:  if (handshake) state_nxt = capture ? SEND_SYNC : IDLE;
         default:                  state_nxt = IDLE;
      endcase
      data_nxt = '0;
      case (state_nxt)
         SEND_SYNC: data_nxt = SYNC_BYTE;
         SEND_CH1:  data_nxt = hold_ch1;
         SEND_CH2:  data_nxt = hold_ch2;
         SEND_CHK:  data_nxt = chk;
         default:   data_nxt = '0;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state         <= IDLE;
         tx.o_tx_valid <= 1'b0;
         tx.o_tx_data  <= '0;
         o_busy        <= 1'b0;
      end else begin
         state         <= state_nxt;
         tx.o_tx_valid <= (state_nxt != IDLE);
         tx.o_tx_data  <= data_nxt;
         o_busy        <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         hold_ch1 <= '0;
         hold_ch2 <= '0;
         chk      <= '0;
      end else if (capture) begin
         hold_ch1 <= i_ch1_data;
         hold_ch2 <= i_ch2_data;
         chk      <= i_ch1_data ^ i_ch2_data ^ SYNC_BYTE;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)                                      o_overrun_count <= '0;
      else if (i_clear_overrun)                          o_overrun_count <= '0;
      else if (tick && !capture && o_overrun_count != 8'hFF) o_overrun_count <= o_overrun_count + 8'd1;
   end
endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed scoreboard bench: stimulus queues expected bytes, a negedge monitor checks transfers.
module tb_adc_frame_scheduler;
   import adc_frame_pkg::*;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_adc_ready = 1'b0;
   logic [15:0] i_decim = 16'd0;
   logic [7:0]  i_ch1_data = 8'h00;
   logic [7:0]  i_ch2_data = 8'h00;
   logic        i_clear_overrun = 1'b0;
   logic [7:0]  o_overrun_count;
   logic        o_busy;

   adc_frame_scheduler_if #(.DATA_SIZE(8)) tx ();

   adc_frame_scheduler dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_enable        (i_enable),
      .i_adc_ready     (i_adc_ready),
      .i_decim         (i_decim),
      .i_ch1_data      (i_ch1_data),
      .i_ch2_data      (i_ch2_data),
      .tx              (tx),
      .i_clear_overrun (i_clear_overrun),
      .o_overrun_count (o_overrun_count),
      .o_busy          (o_busy)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic [7:0] data;
      bit         first;
   } exp_t;

   exp_t exp_q[$];
   int   sync_cyc[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   nbytes = 0;
   int   rdy_mode = 0;
   int   base;
   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic [7:0] pd = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] ck);
      exp_q.push_back('{SYNC_BYTE_DEF, 1'b1});
      exp_q.push_back('{c1, 1'b0});
      exp_q.push_back('{c2, 1'b0});
      exp_q.push_back('{ck, 1'b0});
   endtask

   task automatic step();
      @(posedge i_clock);
      #1;
      cyc++;
      case (rdy_mode)
         1:       tx.i_tx_ready = 1'b1;
         2:       tx.i_tx_ready = (cyc % 3 == 0);
         default: tx.i_tx_ready = 1'b0;
      endcase
   endtask

   task automatic wait_bytes(input int target, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (nbytes >= target) break;
         step();
      end
      chk("bytes_reached", nbytes, target);
   endtask

   // Transfer monitor: every accepted byte is popped and compared; stalls must hold data.
   always @(negedge i_clock) begin
      if (i_reset) begin
         if (pv && !pr) begin
            chk("stall_valid", {31'd0, tx.o_tx_valid}, 1);
            chk("stall_data", {24'd0, tx.o_tx_data}, {24'd0, pd});
         end
         if (tx.o_tx_valid && tx.i_tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {24'd0, tx.o_tx_data}, 32'hFFFF_FFFF);
            end else begin
               chk("tx_byte", {24'd0, tx.o_tx_data}, {24'd0, exp_q[0].data});
               if (exp_q[0].first) sync_cyc.push_back(cyc);
               void'(exp_q.pop_front());
            end
            nbytes <= nbytes + 1;
         end
         pv <= tx.o_tx_valid;
         pr <= tx.i_tx_ready;
         pd <= tx.o_tx_data;
      end else begin
         pv <= 1'b0;
      end
   end

   initial begin
      tx.i_tx_ready = 1'b0;
      // Reset state and idle with enable low
      repeat (3) step();
      chk("rst_valid", {31'd0, tx.o_tx_valid}, 0);
      chk("rst_data", {24'd0, tx.o_tx_data}, 0);
      chk("rst_busy", {31'd0, o_busy}, 0);
      chk("rst_ovr", {24'd0, o_overrun_count}, 0);
      i_reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         repeat (10) step();
         chk("idle_valid", {31'd0, tx.o_tx_valid}, 0);
         chk("idle_ovr", {24'd0, o_overrun_count}, 0);
      end

      // Basic frames every 10 cycles
      rdy_mode = 1; i_adc_ready = 1'b1; i_decim = 16'd9;
      i_ch1_data = 8'h12; i_ch2_data = 8'h34;
      for (int f = 0; f < 3; f++) push_frame(8'h12, 8'h34, 8'h83);
      sync_cyc.delete();
      base = nbytes;
      i_enable = 1'b1;
      wait_bytes(base + 3 * FRAME_LEN, 60);
      i_enable = 1'b0;
      chk("sync_count", sync_cyc.size(), 3);
      if (sync_cyc.size() >= 3) begin
         chk("frame_gap0", sync_cyc[1] - sync_cyc[0], 10);
         chk("frame_gap1", sync_cyc[2] - sync_cyc[1], 10);
      end
      repeat (20) step();
      chk("basic_drain", exp_q.size(), 0);
      chk("basic_ovr", {24'd0, o_overrun_count}, 0);

      // Backpressure: ready 1 of 3 cycles, period long enough to avoid drops
      rdy_mode = 2; i_decim = 16'd15;
      i_ch1_data = 8'h5A; i_ch2_data = 8'hC3;
      for (int f = 0; f < 3; f++) push_frame(8'h5A, 8'hC3, 8'h3C);
      base = nbytes;
      i_enable = 1'b1;
      wait_bytes(base + 3 * FRAME_LEN, 100);
      i_enable = 1'b0;
      repeat (20) step();
      chk("bp_drain", exp_q.size(), 0);
      chk("bp_ovr", {24'd0, o_overrun_count}, 0);

      // Overrun: transmitter stalled, every tick after the first is dropped
      rdy_mode = 0; i_decim = 16'd3;
      i_ch1_data = 8'h01; i_ch2_data = 8'h02;
      push_frame(8'h01, 8'h02, 8'hA6);
      base = nbytes;
      i_enable = 1'b1;
      repeat (12) step();
      chk("ovr_two", {24'd0, o_overrun_count}, 2);
      chk("ovr_stall_data", {24'd0, tx.o_tx_data}, 32'hA5);
      repeat (1100) step();
      chk("ovr_sat", {24'd0, o_overrun_count}, 255);
      i_clear_overrun = 1'b1;
      repeat (8) step();
      chk("ovr_clear_wins", {24'd0, o_overrun_count}, 0);
      i_clear_overrun = 1'b0; i_enable = 1'b0;
      repeat (2) step();
      chk("ovr_cleared", {24'd0, o_overrun_count}, 0);
      rdy_mode = 1;
      wait_bytes(base + FRAME_LEN, 20);
      repeat (3) step();
      chk("ovr_idle", {31'd0, o_busy}, 0);

      // Back-to-back with channels changing every cycle
      i_decim = 16'd3;
      push_frame(8'h13, 8'h33, 8'h85);
      push_frame(8'h17, 8'h77, 8'hC5);
      push_frame(8'h1B, 8'hBB, 8'h05);
      for (int k = 0; k < 16; k++) begin
         i_ch1_data = 8'h10 + 8'(k);
         i_ch2_data = {k[3:0], k[3:0]};
         i_enable   = (k < 12);
         chk("b2b_valid", {31'd0, tx.o_tx_valid}, (k >= 4) ? 1 : 0);
         step();
      end
      chk("b2b_done_valid", {31'd0, tx.o_tx_valid}, 0);
      chk("b2b_done_busy", {31'd0, o_busy}, 0);
      chk("b2b_drain", exp_q.size(), 0);
      chk("b2b_ovr", {24'd0, o_overrun_count}, 0);

      // Gating: ADC not ready, then enable dropped during SEND_CH1
      i_adc_ready = 1'b0; i_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         repeat (10) step();
         chk("gate_valid", {31'd0, tx.o_tx_valid}, 0);
         chk("gate_ovr", {24'd0, o_overrun_count}, 0);
      end
      i_enable = 1'b0; i_adc_ready = 1'b1;
      step();
      i_decim = 16'd9; i_ch1_data = 8'hF0; i_ch2_data = 8'h0F;
      push_frame(8'hF0, 8'h0F, 8'h5A);
      base = nbytes;
      i_enable = 1'b1;
      repeat (11) step();
      chk("gate_ch1_valid", {31'd0, tx.o_tx_valid}, 1);
      chk("gate_ch1_data", {24'd0, tx.o_tx_data}, 32'hF0);
      i_enable = 1'b0;
      wait_bytes(base + FRAME_LEN, 20);
      repeat (30) step();
      chk("gate_idle", {31'd0, o_busy}, 0);
      chk("gate_drain", exp_q.size(), 0);

      // Reset during SEND_CH2 abandons the frame
      i_ch1_data = 8'h11; i_ch2_data = 8'h22;
      exp_q.push_back('{8'hA5, 1'b1});
      exp_q.push_back('{8'h11, 1'b0});
      base = nbytes;
      i_enable = 1'b1;
      repeat (12) step();
      chk("mid_ch2_data", {24'd0, tx.o_tx_data}, 32'h22);
      i_reset = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, tx.o_tx_valid}, 0);
      chk("mid_rst_busy", {31'd0, o_busy}, 0);
      chk("mid_rst_data", {24'd0, tx.o_tx_data}, 0);
      repeat (2) step();
      i_ch1_data = 8'h33; i_ch2_data = 8'h44;
      push_frame(8'h33, 8'h44, 8'hD2);
      i_reset = 1'b1;
      wait_bytes(base + 2 + FRAME_LEN, 30);
      i_enable = 1'b0;
      repeat (20) step();
      chk("rst_drain", exp_q.size(), 0);
      chk("rst_idle", {31'd0, o_busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adc_frame_scheduler.md
# adc_frame_scheduler

Sequences ADC sample transmission between the ADC front end and a single byte-wide serial transmitter. It decimates the free-running channel 1 and channel 2 sample streams and snapshots both channels atomically on each sample tick. It then emits a 4-byte frame (sync, ch1, ch2, checksum) over a valid/ready byte handshake. It sits between the ADC 8-MSB converted outputs and the UART transmitter, and counts samples dropped while a frame is still in flight.

## Interface

Parameters:
- DATA_SIZE, 8, width of channel samples and transmitted bytes
- DECIM_SIZE, 16, width of the decimation compare value
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- i_clock  in  1  system clock (100 MHz domain)
- i_reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- i_enable  in  1  1 = generate sample ticks; 0 = counter held at 0, no new captures
- i_adc_ready  in  1  ADC init done; ticks ignored while 0
- i_decim  in  DECIM_SIZE  tick period minus one (0 = tick every cycle)
- i_ch1_data  in  DATA_SIZE  converted channel 1 sample
- i_ch2_data  in  DATA_SIZE  converted channel 2 sample
- o_tx_data  out  DATA_SIZE  byte to transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts byte this cycle
- i_clear_overrun  in  1  synchronous clear of o_overrun_count
- o_overrun_count  out  8  saturating count of dropped ticks
- o_busy  out  1  frame in progress (state != IDLE)

## Operation

- Decimation counter: when i_enable=1, it increments each cycle. When cnt >= i_decim it asserts a one-cycle tick and reloads 0. Comparing with >= means lowering i_decim below the current count wraps on the next cycle.
- Tick is qualified by i_adc_ready; an unqualified tick has no effect, including no overrun.
- Capture condition: a qualified tick while state=IDLE, or while state=SEND_CHK with the handshake completing in the same cycle.
- On capture, i_ch1_data and i_ch2_data are latched into hold registers, chk = ch1 XOR ch2 XOR SYNC_BYTE is registered, and the FSM goes to SEND_SYNC.
- Qualified tick with no capture: o_overrun_count increments, saturating at 255. If i_clear_overrun is asserted in the same cycle, clear wins.
- FSM states: IDLE, SEND_SYNC, SEND_CH1, SEND_CH2, SEND_CHK.
  - Each SEND state drives its byte with o_tx_valid=1.
  - On o_tx_valid & i_tx_ready it advances: SYNC→CH1→CH2→CHK→IDLE, or CHK→SYNC on back-to-back capture.
- Handshake: o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0. o_tx_valid never drops without a completed transfer, except on reset.
- i_enable falling mid-frame: the current frame completes, then no new captures occur.
- Reset mid-frame: the frame is abandoned. No partial-frame resume.

## Timing

- Reset values: o_tx_valid=0, o_tx_data=0, o_busy=0, o_overrun_count=0, FSM=IDLE, counter=0, hold registers=0.
- Tick at cycle T (IDLE): o_tx_valid=1 with SYNC_BYTE at T+1.
- With i_tx_ready held 1: bytes at T+1..T+4, IDLE at T+5.
- Minimum sustainable period is i_decim=3, using the CHK/capture overlap for back-to-back frames.
- All outputs are registered; no combinational path from i_tx_ready to o_tx_valid/o_tx_data.

## Structure

- Shared package adc_frame_pkg: state enum (IDLE, SEND_SYNC, SEND_CH1, SEND_CH2, SEND_CHK), default SYNC_BYTE, frame length constant 4.
- One sub-module, sample_tick_gen: decimation counter plus enable/ready qualification, outputting a one-cycle tick.
- Top-level scheduler holds the FSM, hold registers, checksum and overrun counter.

## Test plan

- Reset/idle: i_reset=0 then 1, i_enable=0 → o_tx_valid=0, o_overrun_count=0 for 100 cycles.
- Basic frame: i_decim=9, ch1=8'h12, ch2=8'h34, i_tx_ready=1 → bytes A5,12,34,83 (12^34^A5), frames every 10 cycles, no overrun.
- Backpressure: i_tx_ready toggling 1-of-3 cycles → o_tx_data stable while stalled, frames intact. With i_decim=3, o_overrun_count counts dropped ticks and saturates at 255; i_clear_overrun → 0.
- Back-to-back: i_decim=3, i_tx_ready=1 → continuous valid, CHK followed directly by SYNC, overrun stays 0. Channel inputs changing mid-frame do not alter the in-flight bytes.
- Gating: i_adc_ready=0 → no frames, no overrun. i_enable dropped during SEND_CH1 → frame completes, then idle.
- Reset mid-frame: assert i_reset during SEND_CH2 → o_tx_valid=0 immediately; after release, next frame starts with A5.
